spi_master_seq: RTL
===================

// Module: spi_master_seq
// PURPOSE
//  SPI master transaction sequencer: accepts one DATA_W-bit word per valid/ready request and drives cs/sclk/mosi.
//  Samples miso and returns the received word; supports all four SPI modes (mode[1]=CPOL, mode[0]=CPHA).
//  Sits on the host side of our SPI slave FSM and generates the cs/sclk framing that FSM decodes.
// PARAMETERS
//  DATA_W  8  bits per transfer (>=2)
//  DIV_W   8  width of half-period divider input
// PORTS
//  clk        in   1       system clock
//  reset_n    in   1       asynchronous reset, active-low
//  mode       in   2       SPI mode {CPOL,CPHA}, latched at request acceptance
//  div        in   DIV_W   sclk half-period = div+1 clk cycles, latched at acceptance
//  req_valid  in   1       request a transfer
//  req_ready  out  1       high only in IDLE; accept when req_valid&&req_ready
//  tx_data    in   DATA_W  word to send, latched at acceptance
//  rx_valid   out  1       one-cycle pulse: rx_data valid
//  rx_data    out  DATA_W  received word, held until next rx_valid
//  busy       out  1       high in any state other than IDLE
//  cs         out  1       chip select, active-low
//  sclk       out  1       SPI clock
//  mosi       out  1       serial data out
//  miso       in   1       serial data in (one clk of synchroniser is not included; caller provides)
// BEHAVIOUR
//  Reset: cs=1, sclk=0, mosi=0, rx_valid=0, rx_data=0, busy=0, state=IDLE; all outputs registered except req_ready.
//  Timer: a half-period tick fires every div_q+1 clk cycles while not IDLE; restarts on every state change.
//  States: IDLE -> SETUP -> ACTIVE -> HOLD -> GAP -> IDLE.
//   IDLE: cs=1, sclk=CPOL of live mode input; on accept (cycle T) latch mode/div/tx, go SETUP at T+1.
//   SETUP: cs=0 from T+1; CPHA=0: mosi=first bit immediately. One half-period, then ACTIVE.
//   ACTIVE: 2*DATA_W half-periods; sclk toggles on each tick; edge_cnt 0..2*DATA_W-1 (even=leading).
//    CPHA=0: sample miso on leading edges, shift mosi on trailing edges (not after last edge).
//    CPHA=1: shift mosi on leading edges (first leading edge presents first bit), sample on trailing.
//   HOLD: sclk at CPOL, cs=0, one half-period; at exit rx_data<=shift reg, rx_valid=1 for one cycle.
//   GAP: cs=1, one half-period minimum deselect, then IDLE.
//  Total per transfer: (2*DATA_W+3)*(div+1) cycles from cs fall to req_ready; cs low (2*DATA_W+2)*(div+1).
//  Bit order MSB first unless SPI_LSB_FIRST_EN. Mode/div/tx_data changes mid-transfer ignored.
//  div=0: sclk = clk/2 (max rate). req_valid held in non-IDLE states is not accepted (no queue).
//  Reset mid-transfer: immediate cs=1, no rx_valid, partial word discarded; IDLE after release.
//  edge_cnt and timer saturate/wrap never: sized clog2(2*DATA_W) and DIV_W, reloaded per state.
// CONFIGURATION
//  SPI_LSB_FIRST_EN defined: tx shifted out and rx assembled LSB first.
//  Undefined: MSB first. Framing, timing and handshake identical in both builds.
// STRUCTURE
//  Package spi_pkg: state encodings (IDLE..GAP), mode constants MODE0..MODE3, CPOL/CPHA bit indices.
//  Sub-module spi_halfper_timer: DIV_W down-counter, load/enable, emits half-period tick.
//  Top holds FSM, edge counter, tx/rx shift registers, output registers.
// TESTING
//  1 reset_n=0 any time -> cs=1, sclk=0, mosi=0, rx_valid=0, req_ready=1, busy=0.
//  2 mode0, div=1, tx=0xA5, miso=mosi loopback -> rx_data=0xA5, cs low 36 cycles, single rx_valid pulse.
//  3 mode3, div=0, tx=0x3C, miso=1 -> sclk idles high, 16 edges, rx_data=0xFF, ready after 19 cycles.
//  4 mode1 start, drive mode=2 and div=5 after 5th edge -> waveform stays mode1/div as latched.
//  5 reset_n low at edge 7 of mode2 transfer -> cs=1 same cycle, no rx_valid, next request completes normally.
//  6 mode0, tx=0x01: first mosi bit 0 default; with SPI_LSB_FIRST_EN first bit 1, miso 0x80 pattern -> rx 0x01.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master sequencer: FSM state encoding,
// SPI mode constants and the bit positions of CPOL/CPHA inside a mode word.
// Optional build macro used by the top: SPI_LSB_FIRST_EN.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACTIVE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_GAP    = 3'd4
    } spi_state_t;

    // mode = {CPOL, CPHA}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    localparam int CPOL_BIT = 1;
    localparam int CPHA_BIT = 0;

endpackage

// File: rtl/spi_halfper_timer.sv
// Half-period timer for the SPI sequencer. A down-counter reloaded with the
// divider value; tick is high in the last cycle of each half-period, so a
// half-period lasts load_val+1 clk cycles. load restarts the count (used on
// every FSM state change); en gates counting outside IDLE.
module spi_halfper_timer #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             en,
    input  logic [DIV_W-1:0] load_val,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    // End of half-period when the count has run down to zero.
    assign tick = en && (cnt == '0);

    // Counter: restart on load, otherwise count down and auto-reload at zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en) begin
            if (cnt == '0) begin
                cnt <= load_val;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_master_seq.sv
// SPI master transaction sequencer. One DATA_W-bit word per request; drives
// cs/sclk/mosi in any of the four SPI modes and returns the word sampled
// from miso. Build option SPI_LSB_FIRST_EN: shift tx out and assemble rx
// LSB first (default MSB first); framing and timing do not change.
//
// Handshake: req_ready is high only in IDLE. A request is taken in the cycle
// where req_valid && req_ready; mode, div and tx_data are captured then and
// ignored for the rest of the transfer. req_valid while busy is not queued.
// rx_valid is a single-cycle pulse; rx_data holds until the next pulse.
module spi_master_seq
    import spi_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        mode,
    input  logic [DIV_W-1:0]  div,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] tx_data,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              cs,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic [2:0]        dbg_state
);

    localparam int EDGE_W = $clog2(2 * DATA_W);
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);

    spi_state_t        state;
    spi_state_t        state_next;

    // Only CPHA needs latching: CPOL is carried by sclk itself, which is
    // captured at acceptance and returns to it after an even edge count.
    logic              cpha_q;
    logic [DIV_W-1:0]  div_q;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rx_sr;
    logic [EDGE_W-1:0] edge_cnt;

    logic              accept;
    logic              tick;
    logic              state_chg;
    logic              leading;
    logic              last_edge;

    logic              cs_d;
    logic              sclk_d;
    logic              mosi_d;
    logic              busy_d;
    logic              rx_valid_d;
    logic              do_sample;
    logic              do_shift;

`ifdef SPI_LSB_FIRST_EN
    function automatic logic head_bit(input logic [DATA_W-1:0] w);
        return w[0];
    endfunction
    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
        return {1'b0, w[DATA_W-1:1]};
    endfunction
    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic b);
        return {b, w[DATA_W-1:1]};
    endfunction
`else
    function automatic logic head_bit(input logic [DATA_W-1:0] w);
        return w[DATA_W-1];
    endfunction
    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
        return {w[DATA_W-2:0], 1'b0};
    endfunction
    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic b);
        return {w[DATA_W-2:0], b};
    endfunction
`endif

    assign req_ready = (state == ST_IDLE);
    assign accept    = req_valid && req_ready;
    assign state_chg = (state_next != state);
    assign leading   = ~edge_cnt[0];
    assign last_edge = (edge_cnt == LAST_EDGE);
    assign dbg_state = state;

    // Half-period timer restarts on each state change; the very first load
    // at acceptance uses the live divider since div_q is captured that edge.
    spi_halfper_timer #(
        .DIV_W (DIV_W)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (state_chg),
        .en       (state != ST_IDLE),
        .load_val (accept ? div : div_q),
        .tick     (tick)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: each non-IDLE state lasts a whole number of half-periods.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (accept)             state_next = ST_SETUP;
            ST_SETUP:  if (tick)               state_next = ST_ACTIVE;
            ST_ACTIVE: if (tick && last_edge)  state_next = ST_HOLD;
            ST_HOLD:   if (tick)               state_next = ST_GAP;
            ST_GAP:    if (tick)               state_next = ST_IDLE;
            default:                           state_next = ST_IDLE;
        endcase
    end

    // Output/next-value logic for the registered pins and shift controls.
    always_comb begin
        cs_d       = !(state_next inside {ST_SETUP, ST_ACTIVE, ST_HOLD});
        busy_d     = (state_next != ST_IDLE);
        sclk_d     = sclk;
        mosi_d     = mosi;
        rx_valid_d = 1'b0;
        do_sample  = 1'b0;
        do_shift   = 1'b0;
        case (state)
            ST_IDLE: begin
                sclk_d = mode[CPOL_BIT];
                if (accept) begin
                    // CPHA=0 needs the first bit on the wire before the first edge.
                    mosi_d = mode[CPHA_BIT] ? 1'b0 : head_bit(tx_data);
                end
            end
            ST_ACTIVE: begin
                if (tick) begin
                    sclk_d    = ~sclk;
                    do_sample = cpha_q ? !leading : leading;
                    do_shift  = cpha_q ? leading : (!leading && !last_edge);
                    if (do_shift) begin
                        mosi_d = head_bit(tx_sr);
                    end
                end
            end
            ST_HOLD: begin
                rx_valid_d = tick;
            end
            default: begin
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cpha_q   <= 1'b0;
            div_q    <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            edge_cnt <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            busy     <= 1'b0;
            cs       <= 1'b1;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
        end else begin
            if (accept) begin
                cpha_q <= mode[CPHA_BIT];
                div_q  <= div;
                tx_sr  <= mode[CPHA_BIT] ? tx_data : shift_out(tx_data);
                rx_sr  <= '0;
            end else if (do_shift) begin
                tx_sr <= shift_out(tx_sr);
            end
            if (do_sample) begin
                rx_sr <= shift_in(rx_sr, miso);
            end
            if (state_chg) begin
                edge_cnt <= '0;
            end else if ((state == ST_ACTIVE) && tick) begin
                edge_cnt <= edge_cnt + 1'b1;
            end
            if (rx_valid_d) begin
                rx_data <= rx_sr;
            end
            rx_valid <= rx_valid_d;
            busy     <= busy_d;
            cs       <= cs_d;
            sclk     <= sclk_d;
            mosi     <= mosi_d;
        end
    end

endmodule
